boss_pattern_ctrl: RTL

//  Frame-rate sequencer for the boss encounter. Drives the boss datapath's mode strobes
//  (spawn, Boss_exists, hold, back_and_forth, flydown, rise) through a fixed attack

---
 rtl/boss_pattern_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/boss_pattern_ctrl.sv
// Frame-rate sequencer for the boss encounter: walks the attack cycle
// spawn -> hold -> sweeps -> dive -> rise -> hold, and decodes mode strobes from state.
module boss_pattern_ctrl #(
    parameter int SPAWN_FRAMES   = 2,
    parameter int HOLD_FRAMES    = 60,
    parameter int SWEEP_FRAMES   = 180,
    parameter int TIMEOUT_FRAMES = 255
) (
    input  logic       i_frame_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic       i_player_dead,
    input  logic [2:0] i_difficulty,
    input  logic       i_hit_top,
    input  logic       i_hit_bottom,
    input  logic       i_beat_boss,
    output logic       o_spawn,
    output logic       o_boss_exists,
    output logic       o_hold,
    output logic       o_back_and_forth,
    output logic       o_flydown,
    output logic       o_rise,
    output logic       o_boss_fire_en,
    output logic       o_defeated,
    output logic [2:0] o_boss_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SPAWN    = 3'd1,
        S_HOLD     = 3'd2,
        S_SWEEP    = 3'd3,
        S_DIVE     = 3'd4,
        S_RISE     = 3'd5,
        S_DEFEATED = 3'd6
    } state_t;

    localparam logic [8:0] SPAWN_LAST     = 9'(SPAWN_FRAMES - 1);
    localparam logic [8:0] HOLD_LAST_EASY = 9'(HOLD_FRAMES - 1);
    localparam logic [8:0] HOLD_LAST_MED  = 9'((HOLD_FRAMES >> 1) - 1);
    localparam logic [8:0] HOLD_LAST_HARD = 9'((HOLD_FRAMES >> 2) - 1);
    localparam logic [8:0] SWEEP_LAST     = 9'(SWEEP_FRAMES - 1);
    localparam logic [8:0] TIMEOUT_LAST   = 9'(TIMEOUT_FRAMES - 1);

    state_t     r_state;
    state_t     w_next;
    logic [8:0] r_frame_cnt;
    logic [1:0] r_sweep_cnt;
    logic [8:0] w_hold_last;
    logic [1:0] w_sweeps_needed;
    logic       w_first_frame;
    logic       w_unused_diff;

    assign w_unused_diff = i_difficulty[0];
    assign w_first_frame = (r_frame_cnt == 9'd0);

    // Difficulty is live every frame; the medium bit overrides the hard bit.
    always_comb begin
        w_hold_last     = HOLD_LAST_EASY;
        w_sweeps_needed = 2'd3;
        if (i_difficulty[1]) begin
            w_hold_last     = HOLD_LAST_MED;
            w_sweeps_needed = 2'd2;
        end else if (i_difficulty[2]) begin
            w_hold_last     = HOLD_LAST_HARD;
            w_sweeps_needed = 2'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start && !i_player_dead) w_next = S_SPAWN;
            end
            S_SPAWN: begin
                if (i_player_dead)                  w_next = S_IDLE;
                else if (r_frame_cnt == SPAWN_LAST) w_next = S_HOLD;
            end
            S_HOLD: begin
                if (i_beat_boss)                     w_next = S_DEFEATED;
                else if (i_player_dead)              w_next = S_IDLE;
                else if (r_frame_cnt == w_hold_last) w_next = S_SWEEP;
            end
            S_SWEEP: begin
                if (i_beat_boss)                    w_next = S_DEFEATED;
                else if (i_player_dead)             w_next = S_IDLE;
                else if (r_frame_cnt == SWEEP_LAST)
                    w_next = (r_sweep_cnt + 2'd1 == w_sweeps_needed) ? S_DIVE : S_HOLD;
            end
            // Hit flags on the first frame are stale sticky values from the datapath.
            S_DIVE: begin
                if (i_beat_boss)        w_next = S_DEFEATED;
                else if (i_player_dead) w_next = S_IDLE;
                else if ((i_hit_bottom && !w_first_frame) || r_frame_cnt == TIMEOUT_LAST)
                    w_next = S_RISE;
            end
            S_RISE: begin
                if (i_beat_boss)        w_next = S_DEFEATED;
                else if (i_player_dead) w_next = S_IDLE;
                else if ((i_hit_top && !w_first_frame) || r_frame_cnt == TIMEOUT_LAST)
                    w_next = S_HOLD;
            end
            S_DEFEATED: w_next = S_DEFEATED;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_frame_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_frame_cnt <= 9'd0;
            r_sweep_cnt <= 2'd0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)
                r_frame_cnt <= 9'd0;
            else if (r_frame_cnt != 9'd511)
                r_frame_cnt <= r_frame_cnt + 9'd1;
            // A fresh attack cycle or a dive restarts the sweep tally.
            if (w_next != r_state && (w_next == S_SPAWN || w_next == S_DIVE))
                r_sweep_cnt <= 2'd0;
            else if (r_state == S_SWEEP && w_next != S_SWEEP)
                r_sweep_cnt <= r_sweep_cnt + 2'd1;
        end
    end

    always_comb begin
        o_spawn          = 1'b0;
        o_boss_exists    = 1'b0;
        o_hold           = 1'b0;
        o_back_and_forth = 1'b0;
        o_flydown        = 1'b0;
        o_rise           = 1'b0;
        o_boss_fire_en   = 1'b0;
        o_defeated       = 1'b0;
        case (r_state)
            S_SPAWN: o_spawn = 1'b1;
            S_HOLD: begin
                o_boss_exists  = 1'b1;
                o_hold         = 1'b1;
                o_boss_fire_en = 1'b1;
            end
            S_SWEEP: begin
                o_boss_exists    = 1'b1;
                o_back_and_forth = 1'b1;
                o_boss_fire_en   = 1'b1;
            end
            S_DIVE: begin
                o_boss_exists = 1'b1;
                o_flydown     = 1'b1;
            end
            S_RISE: begin
                o_boss_exists = 1'b1;
                o_rise        = 1'b1;
            end
            S_DEFEATED: o_defeated = 1'b1;
            default: ;
        endcase
    end

    assign o_boss_state = r_state;

endmodule
